// File: rtl/pps_qualifier_pkg.sv
// Shared types and widths for the PPS qualifier: FSM state encoding and
// counter widths used by the top level.
package pps_qualifier_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE  = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_HOLDOVER = 2'd2
   } state_t;

   localparam int BAD_W = 8;
   localparam int RUN_W = 4;

endpackage

// File: rtl/pps_qualifier_pulse_stretcher.sv
// Stretches a one-cycle start strobe into an output held high for exactly
// PULSE_WIDTH cycles; a start while busy reloads the full width.
module pulse_stretcher #(
   parameter int PULSE_WIDTH = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_pulse
);

   localparam int CW = $clog2(PULSE_WIDTH + 1);

   logic [CW-1:0] r_left;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_left <= '0;
      end else if (i_start) begin
         r_left <= CW'(PULSE_WIDTH);
      end else if (r_left != '0) begin
         r_left <= r_left - 1'b1;
      end
   end

   assign o_pulse = (r_left != '0);

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level into the local clock
// domain; STAGES flops end to end.
module synchronizer #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pps_qualifier.sv
// Qualifies raw GPS PPS into the MINOR_OUT reference: period measurement, window
// check, lock tracking. Define PPS_QUALIFIER_HOLDOVER_EN to add the HOLDOVER state.
module pps_qualifier
   import pps_qualifier_pkg::*;
#(
   parameter int COUNT_WIDTH    = 32,
   parameter int NOMINAL_PERIOD = 10000000,
   parameter int TOLERANCE      = 1000,
   parameter int LOCK_COUNT     = 4,
   parameter int PULSE_WIDTH    = 16,
   parameter int EXTRA_DEPTH    = 3
) (
   input  logic                   MAJOR_CLOCK,
   input  logic                   RESET,
   input  logic                   PPS_IN,
   output logic                   MINOR_OUT,
   output logic                   LOCKED,
   output logic                   HOLDOVER,
   output logic [COUNT_WIDTH-1:0] PERIOD_LAST,
   output logic                   PERIOD_VALID,
   output logic [BAD_W-1:0]       BAD_COUNT
);

   localparam logic [COUNT_WIDTH-1:0] WIN_LO   = COUNT_WIDTH'(NOMINAL_PERIOD - TOLERANCE);
   localparam logic [COUNT_WIDTH-1:0] WIN_HI   = COUNT_WIDTH'(NOMINAL_PERIOD + TOLERANCE);
   localparam logic [RUN_W-1:0]       RUN_LOCK = RUN_W'(LOCK_COUNT);
`ifdef PPS_QUALIFIER_HOLDOVER_EN
   localparam logic [COUNT_WIDTH-1:0] SYN_PER  = COUNT_WIDTH'(NOMINAL_PERIOD);
`endif

   function automatic logic [COUNT_WIDTH-1:0] sat_inc_cnt(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [BAD_W-1:0] sat_inc_bad(input logic [BAD_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                   w_sync;
   logic                   r_sync_d;
   logic                   w_edge;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic                   r_armed;
   logic [RUN_W-1:0]       r_run;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_in_win;
   logic                   w_timeout;
   logic                   w_reload;
   logic                   w_disarm;
   logic                   w_run_inc;
   logic                   w_run_clr;
   logic                   w_period_upd;
   logic                   w_bad;
   logic                   w_start;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
   logic [COUNT_WIDTH-1:0] r_syn_cnt;
   logic                   w_syn_load;
`endif

   synchronizer #(
      .STAGES (2 + EXTRA_DEPTH)
   ) u_sync (
      .i_clk (MAJOR_CLOCK),
      .i_rst (RESET),
      .i_d   (PPS_IN),
      .o_q   (w_sync)
   );

   always_ff @(posedge MAJOR_CLOCK) begin
      if (RESET) begin
         r_sync_d <= 1'b0;
      end else begin
         r_sync_d <= w_sync;
      end
   end

   assign w_edge    = w_sync & ~r_sync_d;
   assign w_in_win  = (r_cnt >= WIN_LO) && (r_cnt <= WIN_HI);
   // An edge landing exactly on the upper window bound is good, so it masks the timeout.
   assign w_timeout = r_armed && (r_cnt == WIN_HI) && !w_edge;

   always_ff @(posedge MAJOR_CLOCK) begin
      if (RESET) begin
         r_state <= ST_ACQUIRE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_reload     = 1'b0;
      w_disarm     = 1'b0;
      w_run_inc    = 1'b0;
      w_run_clr    = 1'b0;
      w_period_upd = 1'b0;
      w_bad        = 1'b0;
      w_start      = 1'b0;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
      w_syn_load   = 1'b0;
`endif
      case (r_state)
         ST_ACQUIRE: begin
            if (w_edge) begin
               if (!r_armed) begin
                  w_reload = 1'b1;
               end else if (w_in_win) begin
                  w_reload     = 1'b1;
                  w_period_upd = 1'b1;
                  w_run_inc    = 1'b1;
                  if (r_run + 1'b1 == RUN_LOCK) begin
                     w_state_nxt = ST_LOCKED;
                     w_start     = 1'b1;
                  end
               end else begin
                  w_bad     = 1'b1;
                  w_run_clr = 1'b1;
               end
            end else if (w_timeout) begin
               w_run_clr = 1'b1;
               w_disarm  = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_edge) begin
               if (w_in_win) begin
                  w_reload     = 1'b1;
                  w_period_upd = 1'b1;
                  w_start      = 1'b1;
               end else begin
                  w_bad = 1'b1;
               end
            end else if (w_timeout) begin
`ifdef PPS_QUALIFIER_HOLDOVER_EN
               w_state_nxt = ST_HOLDOVER;
               w_start     = 1'b1;
               w_syn_load  = 1'b1;
`else
               w_state_nxt = ST_ACQUIRE;
               w_run_clr   = 1'b1;
               w_disarm    = 1'b1;
`endif
            end
         end
         ST_HOLDOVER: begin
            if (w_edge) begin
               w_state_nxt = ST_ACQUIRE;
               w_reload    = 1'b1;
               w_run_clr   = 1'b1;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
            end else if (r_syn_cnt == SYN_PER) begin
               w_start    = 1'b1;
               w_syn_load = 1'b1;
`endif
            end
         end
         default: begin
            w_state_nxt = ST_ACQUIRE;
         end
      endcase
   end

   always_comb begin
      LOCKED = (r_state == ST_LOCKED);
`ifdef PPS_QUALIFIER_HOLDOVER_EN
      HOLDOVER = (r_state == ST_HOLDOVER);
`else
      HOLDOVER = 1'b0;
`endif
   end

   // Measurement and status registers driven by the decoded FSM actions.
   always_ff @(posedge MAJOR_CLOCK) begin
      if (RESET) begin
         r_cnt        <= '0;
         r_armed      <= 1'b0;
         r_run        <= '0;
         PERIOD_LAST  <= '0;
         PERIOD_VALID <= 1'b0;
         BAD_COUNT    <= '0;
      end else begin
         r_cnt        <= w_reload ? COUNT_WIDTH'(1) : sat_inc_cnt(r_cnt);
         PERIOD_VALID <= w_period_upd;
         if (w_reload) begin
            r_armed <= 1'b1;
         end else if (w_disarm) begin
            r_armed <= 1'b0;
         end
         if (w_run_clr) begin
            r_run <= '0;
         end else if (w_run_inc) begin
            r_run <= r_run + 1'b1;
         end
         if (w_period_upd) begin
            PERIOD_LAST <= r_cnt;
         end
         if (w_bad) begin
            BAD_COUNT <= sat_inc_bad(BAD_COUNT);
         end
      end
   end

`ifdef PPS_QUALIFIER_HOLDOVER_EN
   always_ff @(posedge MAJOR_CLOCK) begin
      if (RESET) begin
         r_syn_cnt <= '0;
      end else if (w_syn_load) begin
         r_syn_cnt <= COUNT_WIDTH'(1);
      end else if (r_state == ST_HOLDOVER) begin
         r_syn_cnt <= sat_inc_cnt(r_syn_cnt);
      end
   end
`endif

   pulse_stretcher #(
      .PULSE_WIDTH (PULSE_WIDTH)
   ) u_stretch (
      .i_clk   (MAJOR_CLOCK),
      .i_rst   (RESET),
      .i_start (w_start),
      .o_pulse (MINOR_OUT)
   );

endmodule

// File: tb/tb_pps_qualifier.sv
// Bench for pps_qualifier: table of PPS edges with a scoreboard of expected
// post-edge outputs, plus hand sequences for loss of PPS, reset and saturation.
module tb_pps_qualifier;

   localparam int NOM = 100;
   localparam int TOL = 2;
   localparam int LCK = 3;
   localparam int PW  = 4;
   localparam int ED  = 0;
`ifdef PPS_QUALIFIER_HOLDOVER_EN
   localparam bit HO_EN = 1'b1;
`else
   localparam bit HO_EN = 1'b0;
`endif

   typedef struct {
      int gap;
      bit lck;
      bit pls;
      bit vld;
      int per;
      int bad;
   } vec_t;

   typedef struct {
      int due;
      int idx;
   } sb_t;

   logic        clk;
   logic        rst;
   logic        pps;
   logic        minor_out;
   logic        locked;
   logic        holdover;
   logic [31:0] period_last;
   logic        period_valid;
   logic [7:0]  bad_count;

   vec_t vec [0:17];
   sb_t  sb [$];
   sb_t  mon_e;
   int   cyc;
   int   n_chk;
   int   n_fail;
   int   last_due;
   int   hi_len;
   bit   rst_cut;

   pps_qualifier #(
      .COUNT_WIDTH    (32),
      .NOMINAL_PERIOD (NOM),
      .TOLERANCE      (TOL),
      .LOCK_COUNT     (LCK),
      .PULSE_WIDTH    (PW),
      .EXTRA_DEPTH    (ED)
   ) dut (
      .MAJOR_CLOCK  (clk),
      .RESET        (rst),
      .PPS_IN       (pps),
      .MINOR_OUT    (minor_out),
      .LOCKED       (locked),
      .HOLDOVER     (holdover),
      .PERIOD_LAST  (period_last),
      .PERIOD_VALID (period_valid),
      .BAD_COUNT    (bad_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard pop side and pulse-width monitor, both sampled mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         if (sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk($sformatf("e%0d_locked", mon_e.idx), locked, vec[mon_e.idx].lck);
            chk($sformatf("e%0d_holdover", mon_e.idx), holdover, 0);
            chk($sformatf("e%0d_minor", mon_e.idx), minor_out, vec[mon_e.idx].pls);
            chk($sformatf("e%0d_pvalid", mon_e.idx), period_valid, vec[mon_e.idx].vld);
            chk($sformatf("e%0d_plast", mon_e.idx), period_last, vec[mon_e.idx].per);
            chk($sformatf("e%0d_bad", mon_e.idx), bad_count, vec[mon_e.idx].bad);
         end else if (sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            chk($sformatf("e%0d_missed_due", mon_e.idx), cyc, mon_e.due);
         end
      end
      if (minor_out === 1'b1) begin
         hi_len++;
      end else begin
         if (hi_len > 0 && !rst_cut) chk("pulse_width", hi_len, PW);
         hi_len = 0;
      end
   end

   task automatic drive_edge(input int idx);
      sb_t s;
      s.due = cyc + 3 + ED;
      s.idx = idx;
      sb.push_back(s);
      last_due = s.due;
      pps = 1'b1;
      @(negedge clk);
      pps = 1'b0;
   endtask

   task automatic run_table(input int a, input int b);
      for (int i = a; i <= b; i++) begin
         if (i > a) repeat (vec[i].gap - 1) @(negedge clk);
         drive_edge(i);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      int d;
      int rises;
      logic prev;
      n_chk   = 0;
      n_fail  = 0;
      hi_len  = 0;
      rst_cut = 1'b0;
      rst     = 1'b1;
      pps     = 1'b0;

      //        gap  lck pls    vld per  bad
      vec[0]  = '{0,   0, 0,     0,  0,  0};
      vec[1]  = '{100, 0, 0,     1, 100, 0};
      vec[2]  = '{100, 0, 0,     1, 100, 0};
      vec[3]  = '{100, 1, 1,     1, 100, 0};
      vec[4]  = '{100, 1, 1,     1, 100, 0};
      vec[5]  = '{98,  1, 1,     1,  98, 0};
      vec[6]  = '{102, 1, 1,     1, 102, 0};
      vec[7]  = '{97,  1, 0,     0, 102, 1};
      vec[8]  = '{6,   0, HO_EN, 0, 102, 1};
      vec[9]  = '{100, 0, 0,     1, 100, 1};
      vec[10] = '{100, 0, 0,     1, 100, 1};
      vec[11] = '{100, 1, 1,     1, 100, 1};
      vec[12] = '{40,  1, 0,     0, 100, 2};
      vec[13] = '{60,  1, 1,     1, 100, 2};
      vec[14] = '{0,   0, 0,     0, 100, 2};
      vec[15] = '{100, 0, 0,     1, 100, 2};
      vec[16] = '{100, 0, 0,     1, 100, 2};
      vec[17] = '{100, 1, 1,     1, 100, 2};

      repeat (3) @(negedge clk);
      chk("rst_minor", minor_out, 0);
      chk("rst_locked", locked, 0);
      chk("rst_holdover", holdover, 0);
      chk("rst_plast", period_last, 0);
      chk("rst_pvalid", period_valid, 0);
      chk("rst_bad", bad_count, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Lock-in, window bounds, late edge timeout, re-lock, glitch.
      run_table(0, 13);

      // PPS stops after lock.
      r = last_due;
      while (cyc < r + 101) @(negedge clk);
      chk("loss_pre_locked", locked, 1);
      chk("loss_pre_holdover", holdover, 0);
      @(negedge clk);
      chk("loss_locked", locked, 0);
      chk("loss_holdover", holdover, HO_EN);
      chk("loss_minor", minor_out, HO_EN);
      rises = 0;
      prev  = minor_out;
      while (cyc < r + 320) begin
         @(negedge clk);
         if (cyc == r + 201) chk("syn_before", minor_out, 0);
         if (cyc == r + 202) chk("syn_at", minor_out, HO_EN);
         if (minor_out && !prev) rises++;
         prev = minor_out;
      end
      chk("syn_rises", rises, HO_EN ? 2 : 0);
      chk("loss_holdover_late", holdover, HO_EN);

      // PPS resumes; re-lock after three good periods.
      while (cyc < r + 330) @(negedge clk);
      run_table(14, 17);

      // Reset during the second MINOR_OUT cycle of the lock pulse.
      d = last_due;
      while (cyc < d + 1) @(negedge clk);
      chk("mid_minor_pre", minor_out, 1);
      rst_cut = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_minor", minor_out, 0);
      chk("mid_locked", locked, 0);
      chk("mid_holdover", holdover, 0);
      chk("mid_plast", period_last, 0);
      chk("mid_pvalid", period_valid, 0);
      chk("mid_bad", bad_count, 0);
      repeat (6) @(negedge clk);
      rst_cut = 1'b0;

      // Edges every two cycles: mostly early, drives BAD_COUNT into saturation.
      for (int k = 0; k < 400; k++) begin
         pps = 1'b1;
         @(negedge clk);
         pps = 1'b0;
         @(negedge clk);
      end
      repeat (6) @(negedge clk);
      chk("bad_saturated", bad_count, 255);
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
